mstr0_frame_writer: RTL

// - Read-side master for the pixel FIFO. Drains show-ahead FIFO words (mstr0_data/data_valid)
//   and writes them to memory as a linear frame of bursts on a req/gnt/ack bus.
// - Sits between the FIFO output (master 0 port) and the memory interconnect.
// - Converts one start command into ceil(frame_words/BURST_LEN) bursts.

---
 rtl/mstr0_frame_writer_if.sv | 25 ++
 rtl/mstr0_frame_writer.sv | 118 +++++++++++
 2 files changed

// File: rtl/mstr0_frame_writer_if.sv
// Memory-side burst write bus (req/gnt address phase, we/ack data beats) of the frame writer.
interface mstr0_frame_writer_if #(
   parameter int DW = 32,
   parameter int AW = 32,
   parameter int LW = 4
);
   logic          bus_req;
   logic          bus_gnt;
   logic [AW-1:0] bus_addr;
   logic [LW-1:0] bus_len;
   logic          bus_we;
   logic [DW-1:0] bus_wdata;
   logic          bus_last;
   logic          bus_ack;

   modport master (
      output bus_req, bus_addr, bus_len, bus_we, bus_wdata, bus_last,
      input  bus_gnt, bus_ack
   );

   modport slave (
      input  bus_req, bus_addr, bus_len, bus_we, bus_wdata, bus_last,
      output bus_gnt, bus_ack
   );
endinterface

// File: rtl/mstr0_frame_writer.sv
// Drains a show-ahead FIFO into memory as a linear frame of bursts (1 cycle start->req, gnt->beat; pop is
// combinational on we&ack, FIFO underrun stalls the burst). MSTR0_FRAME_CHECKSUM_EN adds frame_sum.
module mstr0_frame_writer #(
   parameter int DW        = 32,
   parameter int AW        = 32,
   parameter int CW        = 16,
   parameter int BURST_LEN = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [CW-1:0] frame_words,
   input  logic          data_valid,
   input  logic [DW-1:0] mstr0_data,
   output logic          mstr0_ready,
   mstr0_frame_writer_if.master bus,
   output logic          busy,
   output logic          done
`ifdef MSTR0_FRAME_CHECKSUM_EN
   ,
   output logic [DW-1:0] frame_sum
`endif
);

   localparam int            LW    = $clog2(BURST_LEN + 1);
   localparam logic [AW-1:0] BYTES = AW'(DW / 8);

   typedef enum logic [1:0] {IDLE, REQ, BURST, DONE} state_t;

   state_t        state;
   logic [AW-1:0] addr_q;
   logic [CW-1:0] rem_q;
   logic [LW-1:0] beat_cnt;
   logic [LW-1:0] len_q;
   logic          done_q;
   logic          we;
   logic          beat_ok;
   logic          last_beat;
   logic [CW-1:0] rem_dec;

   function automatic logic [LW-1:0] min_len(input logic [CW-1:0] r);
      if (r >= CW'(BURST_LEN))
         return LW'(BURST_LEN);
      else
         return LW'(r);
   endfunction

   assign we        = (state == BURST) && data_valid;
   assign beat_ok   = we && bus.bus_ack;
   assign last_beat = (beat_cnt == len_q - LW'(1));
   assign rem_dec   = rem_q - CW'(1);

   assign bus.bus_req   = (state == REQ) && data_valid;
   assign bus.bus_addr  = addr_q;
   assign bus.bus_len   = len_q;
   assign bus.bus_we    = we;
   assign bus.bus_wdata = mstr0_data;
   assign bus.bus_last  = we && last_beat;
   assign mstr0_ready   = beat_ok;
   assign busy          = (state != IDLE);
   assign done          = done_q;

   // len_q is loaded whenever a new burst becomes pending so it stays stable from request to last beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         addr_q   <= '0;
         rem_q    <= '0;
         beat_cnt <= '0;
         len_q    <= '0;
         done_q   <= 1'b0;
`ifdef MSTR0_FRAME_CHECKSUM_EN
         frame_sum <= '0;
`endif
      end else begin
         done_q <= (state == DONE);
         case (state)
            IDLE: begin
               if (start) begin
                  addr_q <= base_addr;
                  rem_q  <= frame_words;
                  len_q  <= min_len(frame_words);
`ifdef MSTR0_FRAME_CHECKSUM_EN
                  frame_sum <= '0;
`endif
                  state  <= (frame_words == '0) ? DONE : REQ;
               end
            end
            REQ: begin
               if (bus.bus_req && bus.bus_gnt) begin
                  beat_cnt <= '0;
                  state    <= BURST;
               end
            end
            BURST: begin
               if (beat_ok) begin
                  rem_q <= rem_dec;
`ifdef MSTR0_FRAME_CHECKSUM_EN
                  frame_sum <= frame_sum + mstr0_data;
`endif
                  if (last_beat) begin
                     addr_q   <= addr_q + AW'(len_q) * BYTES;
                     beat_cnt <= '0;
                     len_q    <= min_len(rem_dec);
                     state    <= (rem_dec == '0) ? DONE : REQ;
                  end else begin
                     beat_cnt <= beat_cnt + LW'(1);
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
